// File: rtl/ibex_pkg.sv
// ibex_pkg: shared definitions for the data access unit.
//   DT_WORD/DT_HALF/DT_BYTE : data_type encodings (1x = byte)
//   ls_fsm_e                : load/store FSM states
//   lsu_misaligned()        : 1 if an access has to be split across two words
package ibex_pkg;

  localparam logic [1:0] DT_WORD = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_BYTE = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GNT_MIS,
    WAIT_RVALID_MIS,
    WAIT_GNT,
    WAIT_RVALID
  } ls_fsm_e;

  function automatic logic lsu_misaligned(input logic [1:0] dt, input logic [1:0] off);
    return ((dt == DT_WORD) && (off != 2'b00)) || ((dt == DT_HALF) && (off == 2'b11));
  endfunction

endpackage

// File: rtl/ibex_lsu_data_align.sv
// ibex_lsu_data_align: combinational byte-lane logic for the data access unit.
//   i_data_type  : access width (ibex_pkg encoding)
//   i_addr_off   : address bits [1:0]
//   i_part2      : 1 while the second half of a split access is on the bus
//   i_sign_ext   : sign-extend the load result
//   i_wdata      : store data (rs2)
//   i_rdata_lo   : lower word of the load (first part, or the only word)
//   i_rdata_hi   : upper word of the load (second part of a split access)
//   o_be         : byte enables for the current bus transaction
//   o_wdata      : store data rotated into its byte lanes
//   o_rdata      : aligned and extended load result
module ibex_lsu_data_align
  import ibex_pkg::*;
(
  input  logic [1:0]  i_data_type,
  input  logic [1:0]  i_addr_off,
  input  logic        i_part2,
  input  logic        i_sign_ext,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata_lo,
  input  logic [31:0] i_rdata_hi,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [3:0]  w_mask;
  logic [7:0]  w_be_full;
  logic [31:0] w_shift;
  logic [7:0]  w_unused_hi;

  // The top byte of the upper word can never land in the result.
  assign w_unused_hi = i_rdata_hi[31:24];

  always_comb begin
    w_mask = i_data_type[1] ? 4'b0001 : (i_data_type[0] ? 4'b0011 : 4'b1111);
    // Enables for both words at once; the low nibble is the first word,
    // the high nibble the spill-over into the next word.
    w_be_full = {4'b0000, w_mask} << i_addr_off;
    o_be      = i_part2 ? w_be_full[7:4] : w_be_full[3:0];

    case (i_addr_off)
      2'd0:    o_wdata = i_wdata;
      2'd1:    o_wdata = {i_wdata[23:0], i_wdata[31:24]};
      2'd2:    o_wdata = {i_wdata[15:0], i_wdata[31:16]};
      default: o_wdata = {i_wdata[7:0],  i_wdata[31:8]};
    endcase

    // {hi, lo} >> off*8, keeping only the 32 bits that can matter
    case (i_addr_off)
      2'd0:    w_shift = i_rdata_lo;
      2'd1:    w_shift = {i_rdata_hi[7:0],  i_rdata_lo[31:8]};
      2'd2:    w_shift = {i_rdata_hi[15:0], i_rdata_lo[31:16]};
      default: w_shift = {i_rdata_hi[23:0], i_rdata_lo[31:24]};
    endcase

    if (i_data_type[1])
      o_rdata = {{24{i_sign_ext & w_shift[7]}}, w_shift[7:0]};
    else if (i_data_type[0])
      o_rdata = {{16{i_sign_ext & w_shift[15]}}, w_shift[15:0]};
    else
      o_rdata = w_shift;
  end

endmodule

// File: rtl/ibex_data_access_unit.sv
// ibex_data_access_unit: load/store unit between ID and the data bus.
// Optional feature macro: IBEX_LSU_MISALIGNED_EN
//   defined     : misaligned accesses are split into two bus transactions
//   not defined : misaligned accesses never reach the bus and return an error
// Ports:
//   clk_i, rst_i (async, active high)
//   ID side : data_req_ex_i, data_we_ex_i, data_type_ex_i, data_sign_ext_ex_i,
//             data_wdata_ex_i, adder_result_ex_i -> lsu_addr_incr_req_o,
//             lsu_addr_last_o, lsu_valid_o, load_err_o, store_err_o,
//             regfile_wdata_lsu_o, busy_o
//   Bus side: data_req_o, data_gnt_i, data_addr_o, data_we_o, data_be_o,
//             data_wdata_o, data_rvalid_i, data_err_i, data_rdata_i
module ibex_data_access_unit
  import ibex_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_ex_i,
  input  logic        data_we_ex_i,
  input  logic [1:0]  data_type_ex_i,
  input  logic        data_sign_ext_ex_i,
  input  logic [31:0] data_wdata_ex_i,
  input  logic [31:0] adder_result_ex_i,
  output logic        lsu_addr_incr_req_o,
  output logic [31:0] lsu_addr_last_o,
  output logic        lsu_valid_o,
  output logic        load_err_o,
  output logic        store_err_o,
  output logic [31:0] regfile_wdata_lsu_o,
  output logic        busy_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  input  logic [31:0] data_rdata_i
);

  ls_fsm_e     r_state;
  logic        r_part;     // second part of a split access in flight
  logic [31:0] r_rdata_q;
  logic        r_err_q;
  logic [31:0] r_addr_last;

  logic        w_mis;
  logic        w_accept;
  logic        w_part2;
  logic        w_err;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;

  assign w_mis = lsu_misaligned(data_type_ex_i, adder_result_ex_i[1:0]);

`ifdef IBEX_LSU_MISALIGNED_EN
  assign w_accept            = (r_state == IDLE) && data_req_ex_i;
  assign w_part2             = r_part || (r_state == WAIT_RVALID_MIS);
  assign lsu_addr_incr_req_o = ((r_state == WAIT_RVALID_MIS) && data_rvalid_i) ||
                               ((r_state == WAIT_GNT) && r_part);
  assign lsu_valid_o         = (r_state == WAIT_RVALID) && data_rvalid_i;
  assign w_err               = data_err_i | r_err_q;
  assign data_req_o          = (w_accept) || (r_state == WAIT_GNT_MIS) || (r_state == WAIT_GNT) ||
                               ((r_state == WAIT_RVALID_MIS) && data_rvalid_i);
`else
  // Misaligned access: report the fault one cycle after acceptance; the flag
  // also blocks re-accepting the still-held request in that cycle.
  logic r_mis_err;
  assign w_accept            = (r_state == IDLE) && data_req_ex_i && !r_mis_err;
  assign w_part2             = r_part;
  assign lsu_addr_incr_req_o = 1'b0;
  assign lsu_valid_o         = ((r_state == WAIT_RVALID) && data_rvalid_i) || r_mis_err;
  assign w_err               = r_mis_err | data_err_i | r_err_q;
  assign data_req_o          = (w_accept && !w_mis) || (r_state == WAIT_GNT);
`endif

  assign load_err_o  = lsu_valid_o && w_err && !data_we_ex_i;
  assign store_err_o = lsu_valid_o && w_err && data_we_ex_i;
  assign busy_o      = (r_state != IDLE);

  ibex_lsu_data_align u_align (
    .i_data_type (data_type_ex_i),
    .i_addr_off  (adder_result_ex_i[1:0]),
    .i_part2     (w_part2),
    .i_sign_ext  (data_sign_ext_ex_i),
    .i_wdata     (data_wdata_ex_i),
    .i_rdata_lo  (r_part ? r_rdata_q : data_rdata_i),
    .i_rdata_hi  (data_rdata_i),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_rdata     (w_rdata)
  );

  // Bus fields are only meaningful while requesting; keep them quiet otherwise.
  assign data_addr_o         = data_req_o ? {adder_result_ex_i[31:2], 2'b00} : 32'h0;
  assign data_we_o           = data_req_o & data_we_ex_i;
  assign data_be_o           = data_req_o ? w_be : 4'h0;
  assign data_wdata_o        = data_req_o ? w_wdata : 32'h0;
  assign regfile_wdata_lsu_o = lsu_valid_o ? w_rdata : 32'h0;
  assign lsu_addr_last_o     = r_addr_last;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_part      <= 1'b0;
      r_rdata_q   <= 32'h0;
      r_err_q     <= 1'b0;
      r_addr_last <= 32'h0;
`ifndef IBEX_LSU_MISALIGNED_EN
      r_mis_err   <= 1'b0;
`endif
    end else begin
      if (data_req_o && data_gnt_i) r_addr_last <= adder_result_ex_i;
`ifndef IBEX_LSU_MISALIGNED_EN
      r_mis_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_err_q <= 1'b0;
            r_part  <= 1'b0;
`ifdef IBEX_LSU_MISALIGNED_EN
            if (w_mis) r_state <= data_gnt_i ? WAIT_RVALID_MIS : WAIT_GNT_MIS;
            else       r_state <= data_gnt_i ? WAIT_RVALID     : WAIT_GNT;
`else
            if (w_mis) begin
              r_mis_err   <= 1'b1;
              r_addr_last <= adder_result_ex_i;
            end else begin
              r_state <= data_gnt_i ? WAIT_RVALID : WAIT_GNT;
            end
`endif
          end
        end
`ifdef IBEX_LSU_MISALIGNED_EN
        WAIT_GNT_MIS: if (data_gnt_i) r_state <= WAIT_RVALID_MIS;
        WAIT_RVALID_MIS: begin
          if (data_rvalid_i) begin
            r_rdata_q <= data_rdata_i;
            r_err_q   <= data_err_i;
            r_part    <= 1'b1;
            r_state   <= data_gnt_i ? WAIT_RVALID : WAIT_GNT;
          end
        end
`endif
        WAIT_GNT: if (data_gnt_i) r_state <= WAIT_RVALID;
        WAIT_RVALID: begin
          if (data_rvalid_i) begin
            r_state <= IDLE;
            r_part  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
